alarm_bank_timekeeper: RTL and testbench

//  Time-of-day core with a parametrised bank of independent alarms, snooze and ring auto-timeout.

---
 rtl/alarm_bank_timekeeper.sv | 164 ++++++++++++++++
 tb/tb_alarm_bank_timekeeper.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_bank_timekeeper.sv
// alarm_bank_timekeeper: HH:MM:SS timebase with a bank of alarms, snooze and auto-timeout ringer
module alarm_bank_timekeeper #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int N_ALARMS       = 4,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  localparam int AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                time_wr_en,
  input  logic [4:0]          wr_hours,
  input  logic [5:0]          wr_minutes,
  input  logic [5:0]          wr_seconds,
  input  logic                al_wr_en,
  input  logic [AW-1:0]       al_idx,
  input  logic                al_enable,
  input  logic                snooze,
  input  logic                dismiss,
  output logic [4:0]          hours,
  output logic [5:0]          minutes,
  output logic [5:0]          seconds,
  output logic                tick_1hz,
  output logic                buzzer,
  output logic [AW-1:0]       ringing_idx,
  output logic [N_ALARMS-1:0] al_pending
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);
  typedef enum logic {IDLE, RING} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0] hh_q, hh_d, snz_h;
  logic [5:0] mm_q, mm_d, ss_q, ss_d, snz_mm;
  logic [6:0] snz_m;
  logic tick_q, match_en_q, term, tw_ok, aw_ok;
  logic [4:0] al_h_q [N_ALARMS];
  logic [4:0] al_h_d [N_ALARMS];
  logic [4:0] sn_h_q [N_ALARMS];
  logic [4:0] sn_h_d [N_ALARMS];
  logic [5:0] al_m_q [N_ALARMS];
  logic [5:0] al_m_d [N_ALARMS];
  logic [5:0] sn_m_q [N_ALARMS];
  logic [5:0] sn_m_d [N_ALARMS];
  logic [N_ALARMS-1:0] al_en_q, al_en_d, sn_act_q, sn_act_d, pend_q, pend_d, fire, clr, wclr;
  logic [AW-1:0] ring_idx_q, ring_idx_d;
  logic [7:0] cnt_q, cnt_d;

  // Prescaler and clock counters; a valid time write overrides a coincident increment
  always_comb begin
    term    = presc_q == TERM;
    tw_ok   = time_wr_en && wr_hours <= 5'd23 && wr_minutes <= 6'd59 && wr_seconds <= 6'd59;
    presc_d = (term || tw_ok) ? '0 : presc_q + 1'b1;
    ss_d    = tw_ok ? wr_seconds : !term ? ss_q : (ss_q == 6'd59) ? 6'd0 : ss_q + 6'd1;
    mm_d    = tw_ok ? wr_minutes : !(term && ss_q == 6'd59) ? mm_q :
              (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
    hh_d    = tw_ok ? wr_hours : !(term && ss_q == 6'd59 && mm_q == 6'd59) ? hh_q :
              (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
  end

  // Snooze target is the current HH:MM pushed forward with minute carry and midnight wrap
  always_comb begin
    snz_m  = {1'b0, mm_q} + 7'(SNOOZE_MIN);
    snz_mm = (snz_m >= 7'd60) ? 6'(snz_m - 7'd60) : snz_m[5:0];
    snz_h  = (snz_m < 7'd60) ? hh_q : (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
  end

  // Alarm matching, slot programming and the IDLE/RING servicing machine
  always_comb begin
    aw_ok      = al_wr_en && 32'(al_idx) < N_ALARMS && wr_hours <= 5'd23 && wr_minutes <= 6'd59;
    wclr       = aw_ok ? N_ALARMS'(1) << al_idx : '0;
    fire       = '0;
    clr        = '0;
    sn_act_d   = sn_act_q;
    sn_h_d     = sn_h_q;
    sn_m_d     = sn_m_q;
    al_h_d     = al_h_q;
    al_m_d     = al_m_q;
    al_en_d    = al_en_q;
    state_d    = state_q;
    ring_idx_d = ring_idx_q;
    cnt_d      = cnt_q;
    for (int i = 0; i < N_ALARMS; i++)
      if (match_en_q && al_en_q[i] && ss_q == 6'd0 &&
          (sn_act_q[i] ? (hh_q == sn_h_q[i] && mm_q == sn_m_q[i])
                       : (hh_q == al_h_q[i] && mm_q == al_m_q[i]))) begin
        fire[i]     = 1'b1;
        sn_act_d[i] = 1'b0;
      end
    if (state_q == RING) begin
      cnt_d = cnt_q + 8'(tick_q);
      if (dismiss || cnt_q == 8'(RING_TIMEOUT_S)) begin
        clr[ring_idx_q] = 1'b1;
        state_d         = IDLE;
      end else if (snooze) begin
        clr[ring_idx_q]      = 1'b1;
        sn_act_d[ring_idx_q] = 1'b1;
        sn_h_d[ring_idx_q]   = snz_h;
        sn_m_d[ring_idx_q]   = snz_mm;
        state_d              = IDLE;
      end
    end else if ((pend_q & ~wclr) != '0) begin
      state_d = RING;
      cnt_d   = '0;
      for (int i = N_ALARMS - 1; i >= 0; i--)
        if (pend_q[i] && !wclr[i]) ring_idx_d = AW'(i);
    end
    if (aw_ok) begin
      al_h_d[al_idx]   = wr_hours;
      al_m_d[al_idx]   = wr_minutes;
      al_en_d[al_idx]  = al_enable;
      sn_act_d[al_idx] = 1'b0;
      if (state_q == RING && ring_idx_q == al_idx) state_d = IDLE;
    end
    pend_d = ((pend_q & ~clr) | fire) & ~wclr;
    if (state_d == IDLE) ring_idx_d = '0;
  end

  // State registers; reset drops the buzzer immediately without waiting for a clock
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      tick_q     <= 1'b0;
      match_en_q <= 1'b0;
      al_h_q     <= '{default: '0};
      al_m_q     <= '{default: '0};
      sn_h_q     <= '{default: '0};
      sn_m_q     <= '{default: '0};
      al_en_q    <= '0;
      sn_act_q   <= '0;
      pend_q     <= '0;
      ring_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      tick_q     <= term;
      match_en_q <= term && !tw_ok;
      al_h_q     <= al_h_d;
      al_m_q     <= al_m_d;
      sn_h_q     <= sn_h_d;
      sn_m_q     <= sn_m_d;
      al_en_q    <= al_en_d;
      sn_act_q   <= sn_act_d;
      pend_q     <= pend_d;
      ring_idx_q <= ring_idx_d;
      cnt_q      <= cnt_d;
    end

  assign hours       = hh_q;
  assign minutes     = mm_q;
  assign seconds     = ss_q;
  assign tick_1hz    = tick_q;
  assign buzzer      = state_q == RING;
  assign ringing_idx = ring_idx_q;
  assign al_pending  = pend_q;
endmodule

// File: tb/tb_alarm_bank_timekeeper.sv
// tb_alarm_bank_timekeeper: directed bench with a seconds-of-day reference model
module tb_alarm_bank_timekeeper;
  logic clk = 1'b0, reset = 1'b1;
  logic time_wr_en = 1'b0, al_wr_en = 1'b0, al_enable = 1'b0, snooze = 1'b0, dismiss = 1'b0;
  logic [4:0] wr_hours = '0;
  logic [5:0] wr_minutes = '0, wr_seconds = '0;
  logic [1:0] al_idx = '0;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic tick_1hz, buzzer;
  logic [1:0] ringing_idx;
  logic [3:0] al_pending;
  int checks = 0, failures = 0;

  alarm_bank_timekeeper #(.CLK_HZ(10), .N_ALARMS(4), .SNOOZE_MIN(5), .RING_TIMEOUT_S(3)) dut (
    .clk(clk), .reset(reset), .time_wr_en(time_wr_en), .wr_hours(wr_hours),
    .wr_minutes(wr_minutes), .wr_seconds(wr_seconds), .al_wr_en(al_wr_en), .al_idx(al_idx),
    .al_enable(al_enable), .snooze(snooze), .dismiss(dismiss), .hours(hours), .minutes(minutes),
    .seconds(seconds), .tick_1hz(tick_1hz), .buzzer(buzzer), .ringing_idx(ringing_idx),
    .al_pending(al_pending)
  );

  always #5 clk = ~clk;

  // reference model: time as seconds of day, alarm targets as minutes of day
  int m_t, m_presc, m_cnt, m_ridx;
  bit m_tick, m_men, m_ring;
  int m_al[4], m_st[4];
  bit m_en[4], m_sa[4], m_pend[4];

  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
    end
  endfunction

  function automatic int pv();
    int v = 0;
    for (int i = 0; i < 4; i++) v |= int'(m_pend[i]) << i;
    return v;
  endfunction

  task automatic model_reset();
    m_t = 0; m_presc = 0; m_cnt = 0; m_ridx = 0; m_tick = 0; m_men = 0; m_ring = 0;
    for (int i = 0; i < 4; i++) begin
      m_al[i] = 0; m_st[i] = 0; m_en[i] = 0; m_sa[i] = 0; m_pend[i] = 0;
    end
  endtask

  task automatic model_step();
    bit term, tw, aw, n_ring;
    int n_t, n_presc, n_ridx, n_cnt;
    bit fire[4], clr[4], wclr[4];
    term = m_presc == 9;
    tw = time_wr_en && wr_hours < 24 && wr_minutes < 60 && wr_seconds < 60;
    aw = al_wr_en && wr_hours < 24 && wr_minutes < 60;
    n_presc = (term || tw) ? 0 : m_presc + 1;
    n_t = tw ? wr_hours * 3600 + wr_minutes * 60 + wr_seconds : term ? (m_t + 1) % 86400 : m_t;
    for (int i = 0; i < 4; i++) begin
      clr[i] = 0;
      wclr[i] = 0;
      fire[i] = m_men && m_en[i] && m_t % 60 == 0 && m_t / 60 == (m_sa[i] ? m_st[i] : m_al[i]);
      if (fire[i]) m_sa[i] = 0;
    end
    n_ring = m_ring; n_ridx = m_ridx; n_cnt = m_cnt;
    if (m_ring) begin
      n_cnt = m_cnt + int'(m_tick);
      if (dismiss || m_cnt == 3) begin
        clr[m_ridx] = 1; n_ring = 0;
      end else if (snooze) begin
        clr[m_ridx] = 1; m_sa[m_ridx] = 1; m_st[m_ridx] = (m_t / 60 + 5) % 1440; n_ring = 0;
      end
    end
    if (aw) begin
      m_al[al_idx] = wr_hours * 60 + wr_minutes;
      m_en[al_idx] = al_enable;
      m_sa[al_idx] = 0;
      wclr[al_idx] = 1;
      if (m_ring && m_ridx == al_idx) n_ring = 0;
    end
    if (!m_ring)
      for (int i = 3; i >= 0; i--)
        if (m_pend[i] && !wclr[i]) begin
          n_ring = 1; n_ridx = i; n_cnt = 0;
        end
    for (int i = 0; i < 4; i++) m_pend[i] = ((m_pend[i] && !clr[i]) || fire[i]) && !wclr[i];
    m_ring = n_ring; m_ridx = n_ring ? n_ridx : 0; m_cnt = n_cnt;
    m_t = n_t; m_presc = n_presc; m_tick = term; m_men = term && !tw;
  endtask

  // every-cycle comparison of all outputs against the model
  always @(negedge clk)
    if (!reset) begin
      chk("hours", hours, m_t / 3600);
      chk("minutes", minutes, (m_t / 60) % 60);
      chk("seconds", seconds, m_t % 60);
      chk("tick", tick_1hz, m_tick);
      chk("buzzer", buzzer, m_ring);
      chk("ringing_idx", ringing_idx, m_ridx);
      chk("pending", al_pending, pv());
    end

  task automatic cyc();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic tw(input int h, input int m, input int s);
    time_wr_en = 1; wr_hours = 5'(h); wr_minutes = 6'(m); wr_seconds = 6'(s);
    cyc();
    time_wr_en = 0;
  endtask

  task automatic aw(input int i, input int h, input int m, input bit en);
    al_wr_en = 1; al_idx = 2'(i); wr_hours = 5'(h); wr_minutes = 6'(m); al_enable = en;
    cyc();
    al_wr_en = 0;
  endtask

  task automatic do_dismiss();
    dismiss = 1; cyc(); dismiss = 0;
  endtask

  task automatic wait_buzz(input bit v, input int max, input string n);
    int k = 0;
    while (buzzer !== v && k < max) begin
      cyc();
      k++;
    end
    chk(n, buzzer, v);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int tk, hi, k;
    model_reset();
    run(3);
    reset = 0;
    chk("rst_hours", hours, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_tick", tick_1hz, 0);
    chk("rst_pending", al_pending, 0);
    chk("rst_ridx", ringing_idx, 0);
    // rollover across midnight and tick spacing
    tw(23, 59, 58);
    tk = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      tk += int'(tick_1hz);
      if (i == 9) chk("roll_mid_sec", seconds, 59);
    end
    chk("roll_ticks", tk, 2);
    chk("roll_h", hours, 0);
    chk("roll_m", minutes, 0);
    chk("roll_s", seconds, 0);
    // basic alarm on slot 2
    aw(2, 7, 0, 1);
    tw(6, 59, 59);
    run(11);
    chk("basic_pending", al_pending, 4);
    chk("basic_buzz_early", buzzer, 0);
    cyc();
    chk("basic_buzz", buzzer, 1);
    chk("basic_ridx", ringing_idx, 2);
    do_dismiss();
    chk("basic_dismiss", buzzer, 0);
    chk("basic_clr", al_pending, 0);
    // snooze across midnight
    aw(2, 7, 0, 0);
    aw(0, 23, 58, 1);
    tw(23, 57, 59);
    wait_buzz(1, 15, "snz_ring");
    chk("snz_ridx", ringing_idx, 0);
    snooze = 1; cyc(); snooze = 0;
    chk("snz_drop", buzzer, 0);
    hi = 0; k = 0;
    while (!(hours == 0 && minutes == 2 && seconds == 59) && k < 4000) begin
      cyc();
      hi += int'(buzzer);
      k++;
    end
    chk("snz_reach", int'(k < 4000), 1);
    chk("snz_no_early", hi, 0);
    wait_buzz(1, 30, "snz_rering");
    chk("snz_rering_m", minutes, 3);
    chk("snz_rering_s", seconds, 0);
    do_dismiss();
    // priority and ring timeout
    aw(0, 0, 0, 0);
    aw(1, 8, 0, 1);
    aw(3, 8, 0, 1);
    tw(7, 59, 59);
    wait_buzz(1, 15, "pri_ring");
    chk("pri_ridx", ringing_idx, 1);
    chk("pri_pending", al_pending, 10);
    wait_buzz(0, 50, "to_drop");
    chk("to_pending", al_pending, 8);
    cyc();
    chk("to_next_buzz", buzzer, 1);
    chk("to_next_ridx", ringing_idx, 3);
    do_dismiss();
    // illegal writes leave state untouched
    tw(12, 34, 56);
    tw(24, 0, 0);
    chk("ill_h", hours, 12);
    tw(12, 60, 0);
    chk("ill_m", minutes, 34);
    chk("ill_s", seconds, 56);
    aw(1, 24, 0, 1);
    aw(1, 5, 60, 1);
    // write on a tick cycle: loaded value held, never a match
    aw(1, 11, 22, 1);
    tw(10, 0, 0);
    run(9);
    tw(11, 22, 0);
    chk("wtick_tick", tick_1hz, 1);
    chk("wtick_s", seconds, 0);
    chk("wtick_m", minutes, 22);
    run(2);
    chk("wtick_nomatch", al_pending, 0);
    run(10);
    chk("wtick_next", seconds, 1);
    aw(1, 0, 0, 0);
    // asynchronous reset while ringing
    aw(3, 9, 0, 1);
    tw(8, 59, 59);
    wait_buzz(1, 15, "ar_ring");
    #2 reset = 1;
    #1;
    chk("ar_buzz", buzzer, 0);
    chk("ar_h", hours, 0);
    chk("ar_m", minutes, 0);
    chk("ar_pending", al_pending, 0);
    model_reset();
    run(2);
    reset = 0;
    tw(8, 59, 59);
    run(15);
    chk("ar_slots_off", buzzer, 0);
    chk("ar_no_pend", al_pending, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
